// File: rtl/mesh_term_fifo_bank_if.sv
// Signal bundle between the agent/mesh side and the terminal FIFO bank.
interface mesh_term_fifo_bank_if #(
  parameter int NTERM   = 8,
  parameter int pckg_sz = 20,
  parameter int CW      = 3,
  parameter int CNT_W   = 8
);
  // Handshake: pndng_i_in[i] is "valid" for the head on data_out_i_in; popin[i]
  // consumes it on the edge where it is sampled high. push[i] is accepted on its
  // edge with no back-pressure; when full it is dropped or overwrites the oldest.
  logic [NTERM-1:0]         push;
  logic [NTERM*pckg_sz-1:0] data_in;
  logic [NTERM-1:0]         popin;
  logic                     clr_stat;
  logic [NTERM-1:0]         pndng_i_in;
  logic [NTERM*pckg_sz-1:0] data_out_i_in;
  logic [NTERM-1:0]         full;
  logic [NTERM*CW-1:0]      count;
  logic [NTERM*CNT_W-1:0]   ovf_cnt;
  logic [NTERM-1:0]         udf;

  modport master (
    output push, data_in, popin, clr_stat,
    input  pndng_i_in, data_out_i_in, full, count, ovf_cnt, udf
  );

  modport slave (
    input  push, data_in, popin, clr_stat,
    output pndng_i_in, data_out_i_in, full, count, ovf_cnt, udf
  );
endinterface

// File: rtl/mesh_term_fifo_bank.sv
// Bank of independent first-word-fall-through FIFOs feeding the mesh terminals,
// with overflow policy, saturating drop counters and a sticky underflow flag.
module mesh_term_fifo_bank #(
  parameter int ROWS       = 2,
  parameter int COLUMS     = 2,
  parameter int NTERM      = 2*ROWS + 2*COLUMS,
  parameter int pckg_sz    = 20,
  parameter int fifo_depth = 4,
  parameter int OVF_MODE   = 0,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mesh_term_fifo_bank_if.slave bus
);
  localparam int CW = $clog2(fifo_depth + 1);
  localparam int PW = $clog2(fifo_depth);
  localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth);
  localparam logic [PW-1:0] LAST_C  = PW'(fifo_depth - 1);

  logic [NTERM-1:0]         pndng_w;
  logic [NTERM-1:0]         full_w;
  logic [NTERM-1:0]         udf_w;
  logic [NTERM*pckg_sz-1:0] dout_w;
  logic [NTERM*CW-1:0]      count_w;
  logic [NTERM*CNT_W-1:0]   ovf_w;

  for (genvar i = 0; i < NTERM; i++) begin : g_ch
    logic [pckg_sz-1:0] mem_q [fifo_depth];
    logic [pckg_sz-1:0] mem_d [fifo_depth];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CNT_W-1:0]   ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               is_empty, is_full, do_wr, do_rd, ovf_evt, udf_evt;

    always_comb begin
      is_empty = (count_q == '0);
      is_full  = (count_q == DEPTH_C);
      ovf_evt  = bus.push[i] && !bus.popin[i] && is_full;
      udf_evt  = bus.popin[i] && is_empty;
      // Overwrite mode turns an overflow into a write plus an implicit pop of the oldest entry.
      do_wr    = bus.push[i] && (!ovf_evt || (OVF_MODE == 1));
      do_rd    = (bus.popin[i] && !is_empty) || (ovf_evt && (OVF_MODE == 1));

      mem_d = mem_q;
      if (do_wr) mem_d[wr_ptr_q] = bus.data_in[i*pckg_sz +: pckg_sz];

      wr_ptr_d = wr_ptr_q;
      if (do_wr) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
      rd_ptr_d = rd_ptr_q;
      if (do_rd) rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;

      count_d = count_q;
      if (do_wr && !do_rd)      count_d = count_q + 1'b1;
      else if (do_rd && !do_wr) count_d = count_q - 1'b1;

      // A clear coinciding with an event keeps that event recorded.
      ovf_d = ovf_q;
      if (bus.clr_stat) begin
        ovf_d    = '0;
        ovf_d[0] = ovf_evt;
      end else if (ovf_evt && (ovf_q != '1)) begin
        ovf_d = ovf_q + 1'b1;
      end
      udf_d = udf_evt | (udf_q & !bus.clr_stat);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        ovf_q    <= '0;
        udf_q    <= 1'b0;
      end else begin
        mem_q    <= mem_d;
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
        ovf_q    <= ovf_d;
        udf_q    <= udf_d;
      end
    end

    assign pndng_w[i]                       = !is_empty;
    assign full_w[i]                        = is_full;
    assign udf_w[i]                         = udf_q;
    assign dout_w[i*pckg_sz +: pckg_sz]     = is_empty ? '0 : mem_q[rd_ptr_q];
    assign count_w[i*CW +: CW]              = count_q;
    assign ovf_w[i*CNT_W +: CNT_W]          = ovf_q;
  end

  assign bus.pndng_i_in    = pndng_w;
  assign bus.full          = full_w;
  assign bus.udf           = udf_w;
  assign bus.data_out_i_in = dout_w;
  assign bus.count         = count_w;
  assign bus.ovf_cnt       = ovf_w;
endmodule

// File: tb/tb_mesh_term_fifo_bank.sv
// Bench for mesh_term_fifo_bank: drop-mode depth 4, overwrite-mode depth 4 and
// drop-mode depth 3 instances share one stimulus bus.
module tb_mesh_term_fifo_bank;
  localparam int NT = 8;
  localparam int PW = 20;
  localparam int OW = 8;

  localparam logic [PW-1:0] DA = 20'hA000A;
  localparam logic [PW-1:0] DB = 20'hB000B;
  localparam logic [PW-1:0] DC = 20'hC000C;
  localparam logic [PW-1:0] DD = 20'hD000D;
  localparam logic [PW-1:0] DE = 20'hE000E;
  localparam logic [PW-1:0] DF = 20'hF000F;
  localparam logic [PW-1:0] DG = 20'h16161;
  localparam logic [PW-1:0] DH = 20'h27272;

  typedef struct {
    logic          pnd;
    logic [PW-1:0] head;
    logic [3:0]    cnt;
    logic          full;
    logic [OW-1:0] ovf;
    logic          udf;
  } obs_t;

  typedef struct {
    logic          rst;
    logic          clr;
    logic [NT-1:0] p;
    logic [NT-1:0] q;
    logic [PW-1:0] d;
    int            ch;
    obs_t          e;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NT-1:0]    push = '0;
  logic [NT-1:0]    popin = '0;
  logic [NT*PW-1:0] data_in = '0;
  logic             clr_stat = 1'b0;

  int errs = 0;
  int checks = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] mq[NT][$];
  vec_t vt[20];

  mesh_term_fifo_bank_if #(.NTERM(NT), .pckg_sz(PW), .CW(3), .CNT_W(OW)) if0 ();
  mesh_term_fifo_bank_if #(.NTERM(NT), .pckg_sz(PW), .CW(3), .CNT_W(OW)) if1 ();
  mesh_term_fifo_bank_if #(.NTERM(NT), .pckg_sz(PW), .CW(2), .CNT_W(OW)) if3 ();

  assign if0.push = push;  assign if0.popin = popin;  assign if0.data_in = data_in;  assign if0.clr_stat = clr_stat;
  assign if1.push = push;  assign if1.popin = popin;  assign if1.data_in = data_in;  assign if1.clr_stat = clr_stat;
  assign if3.push = push;  assign if3.popin = popin;  assign if3.data_in = data_in;  assign if3.clr_stat = clr_stat;

  mesh_term_fifo_bank #(.ROWS(2), .COLUMS(2), .pckg_sz(PW), .fifo_depth(4), .OVF_MODE(0), .CNT_W(OW))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  mesh_term_fifo_bank #(.ROWS(2), .COLUMS(2), .pckg_sz(PW), .fifo_depth(4), .OVF_MODE(1), .CNT_W(OW))
    dut1 (.clk(clk), .reset(reset), .bus(if1));
  mesh_term_fifo_bank #(.ROWS(2), .COLUMS(2), .pckg_sz(PW), .fifo_depth(3), .OVF_MODE(0), .CNT_W(OW))
    dut3 (.clk(clk), .reset(reset), .bus(if3));

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic c, input logic [NT-1:0] p,
                      input logic [NT-1:0] q, input logic [NT*PW-1:0] din);
    reset = r; clr_stat = c; push = p; popin = q; data_in = din;
    @(posedge clk);
    #1;
    reset = 1'b0; clr_stat = 1'b0; push = '0; popin = '0;
  endtask

  task automatic sample(input int d, input int ch, output obs_t o);
    o = '{1'b0, '0, 4'd0, 1'b0, '0, 1'b0};
    case (d)
      0: begin
        o.pnd = if0.pndng_i_in[ch]; o.head = if0.data_out_i_in[ch*PW +: PW];
        o.cnt = 4'(if0.count[ch*3 +: 3]); o.full = if0.full[ch];
        o.ovf = if0.ovf_cnt[ch*OW +: OW]; o.udf = if0.udf[ch];
      end
      1: begin
        o.pnd = if1.pndng_i_in[ch]; o.head = if1.data_out_i_in[ch*PW +: PW];
        o.cnt = 4'(if1.count[ch*3 +: 3]); o.full = if1.full[ch];
        o.ovf = if1.ovf_cnt[ch*OW +: OW]; o.udf = if1.udf[ch];
      end
      default: begin
        o.pnd = if3.pndng_i_in[ch]; o.head = if3.data_out_i_in[ch*PW +: PW];
        o.cnt = 4'(if3.count[ch*2 +: 2]); o.full = if3.full[ch];
        o.ovf = if3.ovf_cnt[ch*OW +: OW]; o.udf = if3.udf[ch];
      end
    endcase
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".pndng"}, 32'(a.pnd),  32'(e.pnd));
    chk({tag, ".head"},  32'(a.head), 32'(e.head));
    chk({tag, ".count"}, 32'(a.cnt),  32'(e.cnt));
    chk({tag, ".full"},  32'(a.full), 32'(e.full));
    chk({tag, ".ovf"},   32'(a.ovf),  32'(e.ovf));
    chk({tag, ".udf"},   32'(a.udf),  32'(e.udf));
  endtask

  function automatic vec_t mk(input logic r, input logic c, input logic [NT-1:0] p,
                              input logic [NT-1:0] q, input logic [PW-1:0] d, input int ch,
                              input logic pn, input logic [PW-1:0] h, input logic [3:0] cn,
                              input logic fu, input logic [OW-1:0] ov, input logic ud);
    vec_t v;
    v.rst = r; v.clr = c; v.p = p; v.q = q; v.d = d; v.ch = ch;
    v.e.pnd = pn; v.e.head = h; v.e.cnt = cn; v.e.full = fu; v.e.ovf = ov; v.e.udf = ud;
    return v;
  endfunction

  initial begin
    obs_t o;
    logic [NT-1:0] p, q;
    logic [NT*PW-1:0] din;
    logic [PW-1:0] d;
    logic [PW-1:0] ehead;
    int eovf[NT];

    // rst clr push   pop    data       ch   pnd head       cnt  full ovf    udf
    vt[0]  = mk(1'b1, 1'b0, 8'h00, 8'h00, 20'h0,     0, 1'b0, 20'h0,     4'd0, 1'b0, 8'd0, 1'b0);
    vt[1]  = mk(1'b0, 1'b0, 8'h01, 8'h00, 20'h12345, 0, 1'b1, 20'h12345, 4'd1, 1'b0, 8'd0, 1'b0);
    vt[2]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 20'h0,     1, 1'b0, 20'h0,     4'd0, 1'b0, 8'd0, 1'b0);
    vt[3]  = mk(1'b0, 1'b0, 8'h20, 8'h00, DA,        5, 1'b1, DA,        4'd1, 1'b0, 8'd0, 1'b0);
    vt[4]  = mk(1'b0, 1'b0, 8'h20, 8'h00, DB,        5, 1'b1, DA,        4'd2, 1'b0, 8'd0, 1'b0);
    vt[5]  = mk(1'b0, 1'b0, 8'h20, 8'h00, DC,        5, 1'b1, DA,        4'd3, 1'b0, 8'd0, 1'b0);
    vt[6]  = mk(1'b0, 1'b0, 8'h20, 8'h00, DD,        5, 1'b1, DA,        4'd4, 1'b1, 8'd0, 1'b0);
    vt[7]  = mk(1'b0, 1'b0, 8'h20, 8'h00, DE,        5, 1'b1, DA,        4'd4, 1'b1, 8'd1, 1'b0);
    vt[8]  = mk(1'b0, 1'b0, 8'h20, 8'h20, DF,        5, 1'b1, DB,        4'd4, 1'b1, 8'd1, 1'b0);
    vt[9]  = mk(1'b0, 1'b0, 8'h00, 8'h80, 20'h0,     7, 1'b0, 20'h0,     4'd0, 1'b0, 8'd0, 1'b1);
    vt[10] = mk(1'b0, 1'b0, 8'h80, 8'h80, DG,        7, 1'b1, DG,        4'd1, 1'b0, 8'd0, 1'b1);
    vt[11] = mk(1'b0, 1'b0, 8'h20, 8'h00, DH,        5, 1'b1, DB,        4'd4, 1'b1, 8'd2, 1'b0);
    vt[12] = mk(1'b0, 1'b1, 8'h20, 8'h00, DH,        5, 1'b1, DB,        4'd4, 1'b1, 8'd1, 1'b0);
    vt[13] = mk(1'b0, 1'b1, 8'h00, 8'h00, 20'h0,     5, 1'b1, DB,        4'd4, 1'b1, 8'd0, 1'b0);
    vt[14] = mk(1'b0, 1'b0, 8'h00, 8'h00, 20'h0,     7, 1'b1, DG,        4'd1, 1'b0, 8'd0, 1'b0);
    vt[15] = mk(1'b0, 1'b1, 8'h00, 8'h40, 20'h0,     6, 1'b0, 20'h0,     4'd0, 1'b0, 8'd0, 1'b1);
    vt[16] = mk(1'b0, 1'b0, 8'h01, 8'h00, DH,        0, 1'b1, 20'h12345, 4'd2, 1'b0, 8'd0, 1'b0);
    vt[17] = mk(1'b1, 1'b0, 8'h01, 8'h00, DA,        0, 1'b0, 20'h0,     4'd0, 1'b0, 8'd0, 1'b0);
    vt[18] = mk(1'b0, 1'b0, 8'h00, 8'h00, 20'h0,     5, 1'b0, 20'h0,     4'd0, 1'b0, 8'd0, 1'b0);
    vt[19] = mk(1'b0, 1'b0, 8'h00, 8'h00, 20'h0,     6, 1'b0, 20'h0,     4'd0, 1'b0, 8'd0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      step(vt[k].rst, vt[k].clr, vt[k].p, vt[k].q, {NT{vt[k].d}});
      sample(0, vt[k].ch, o);
      chk_obs($sformatf("vec%0d.ch%0d", k, vt[k].ch), o, vt[k].e);
    end
    for (int ch = 0; ch < NT; ch++) begin
      sample(0, ch, o);
      chk($sformatf("post_reset.ch%0d.count", ch), 32'(o.cnt), 32'd0);
      chk($sformatf("post_reset.ch%0d.head", ch), 32'(o.head), 32'd0);
    end

    // Back-to-back drain of channel 3 in push order.
    step(1'b1, 1'b0, '0, '0, '0);
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      d = 20'h30000 + PW'(k);
      exp_q.push_back(d);
      step(1'b0, 1'b0, 8'h08, 8'h00, {NT{d}});
    end
    sample(0, 3, o);
    chk("b2b.full3", 32'(o.full), 32'd1);
    for (int k = 0; k < 4; k++) begin
      sample(0, 3, o);
      chk($sformatf("b2b.head%0d", k), 32'(o.head), 32'(exp_q.pop_front()));
      step(1'b0, 1'b0, 8'h00, 8'h08, '0);
    end
    sample(0, 3, o);
    chk("b2b.pndng3_after", 32'(o.pnd), 32'd0);
    chk("b2b.head3_after", 32'(o.head), 32'd0);

    // Depth-3 wrap-around with occupancy alternating 3/2 on channel 1.
    step(1'b1, 1'b0, '0, '0, '0);
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      d = 20'h50000 + PW'(k);
      exp_q.push_back(d);
      step(1'b0, 1'b0, 8'h02, 8'h00, {NT{d}});
      if (k >= 2) begin
        sample(2, 1, o);
        chk($sformatf("wrap.full_k%0d", k), 32'(o.full), 32'd1);
        chk($sformatf("wrap.head_k%0d", k), 32'(o.head), 32'(exp_q.pop_front()));
        step(1'b0, 1'b0, 8'h00, 8'h02, '0);
        sample(2, 1, o);
        chk($sformatf("wrap.count_k%0d", k), 32'(o.cnt), 32'd2);
      end
    end
    for (int k = 0; k < 2; k++) begin
      sample(2, 1, o);
      chk($sformatf("wrap.drain%0d", k), 32'(o.head), 32'(exp_q.pop_front()));
      step(1'b0, 1'b0, 8'h00, 8'h02, '0);
    end
    sample(2, 1, o);
    chk("wrap.ovf", 32'(o.ovf), 32'd0);
    chk("wrap.pndng_end", 32'(o.pnd), 32'd0);

    // Overwrite-oldest policy on channel 2, then counter saturation and clear.
    step(1'b1, 1'b0, '0, '0, '0);
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      d = 20'h70000 + PW'(k);
      exp_q.push_back(d);
      step(1'b0, 1'b0, 8'h04, 8'h00, {NT{d}});
    end
    void'(exp_q.pop_front());
    sample(1, 2, o);
    chk("ovw.head", 32'(o.head), 32'h70001);
    chk("ovw.count", 32'(o.cnt), 32'd4);
    chk("ovw.ovf", 32'(o.ovf), 32'd1);
    for (int k = 0; k < 4; k++) begin
      sample(1, 2, o);
      chk($sformatf("ovw.drain%0d", k), 32'(o.head), 32'(exp_q.pop_front()));
      step(1'b0, 1'b0, 8'h00, 8'h04, '0);
    end
    for (int k = 0; k < 304; k++) step(1'b0, 1'b0, 8'h04, 8'h00, {NT{PW'(k)}});
    sample(1, 2, o);
    chk("ovw.sat", 32'(o.ovf), 32'd255);
    chk("ovw.head_after_300", 32'(o.head), 32'd300);
    chk("ovw.full_after_300", 32'(o.full), 32'd1);
    step(1'b0, 1'b1, '0, '0, '0);
    sample(1, 2, o);
    chk("ovw.clr", 32'(o.ovf), 32'd0);

    // Random traffic on the drop-mode bank against per-channel queues.
    step(1'b1, 1'b0, '0, '0, '0);
    for (int ch = 0; ch < NT; ch++) begin
      mq[ch].delete();
      eovf[ch] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int ch = 0; ch < NT; ch++) begin
        p[ch] = ($urandom_range(0, 99) < 60);
        q[ch] = ($urandom_range(0, 99) < 45);
        din[ch*PW +: PW] = PW'($urandom_range(0, 20'hFFFFF));
        if (p[ch] && !q[ch] && mq[ch].size() == 4 && eovf[ch] < 255) eovf[ch]++;
        if (q[ch] && mq[ch].size() > 0) void'(mq[ch].pop_front());
        if (p[ch] && mq[ch].size() < 4) mq[ch].push_back(din[ch*PW +: PW]);
      end
      step(1'b0, 1'b0, p, q, din);
      for (int ch = 0; ch < NT; ch++) begin
        sample(0, ch, o);
        ehead = (mq[ch].size() > 0) ? mq[ch][0] : '0;
        chk($sformatf("rnd.c%0d.ch%0d.count", cyc, ch), 32'(o.cnt), 32'(mq[ch].size()));
        chk($sformatf("rnd.c%0d.ch%0d.head", cyc, ch), 32'(o.head), 32'(ehead));
      end
    end
    for (int ch = 0; ch < NT; ch++) begin
      sample(0, ch, o);
      chk($sformatf("rnd.ch%0d.ovf", ch), 32'(o.ovf), 32'(eovf[ch]));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
